// File: rtl/step_drv_pkg.sv
// Shared definitions for the stepper driver: FSM state encoding and coil patterns.
// Build option: define STEP_HALF_EN for the 8-entry half-step sequence; otherwise
// the 4-entry two-phase full-step sequence is used.
package step_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_t;

`ifdef STEP_HALF_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  // Coil pattern {A, B, A_n, B_n} for a phase index. The sequence lengths are powers
  // of two, so the phase index wraps naturally at its own width.
  function automatic logic [3:0] coil_pattern(input logic [PH_W-1:0] idx);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef STEP_HALF_EN
    case (idx)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      3'd7: pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`else
    case (idx)
      2'd0: pat = 4'b1100;
      2'd1: pat = 4'b0110;
      2'd2: pat = 4'b0011;
      2'd3: pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`endif
    return pat;
  endfunction

endpackage

// File: rtl/step_seq.sv
// Phase sequencer: owns the phase index and the registered coil drive.
// Build option STEP_HALF_EN selects half-step patterns (via step_drv_pkg).
module step_seq
  import step_drv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       dir,
  input  logic       run,
  output logic [3:0] coil
);

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_next;

  // Advance or retreat the phase index by one on each step.
  always_comb begin
    phase_next = phase;
    if (step) begin
      phase_next = dir ? phase + 1'b1 : phase - 1'b1;
    end
  end

  // Hold the phase index and drive the coils only while the motor is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      coil  <= 4'b0000;
    end else begin
      phase <= phase_next;
      coil  <= run ? coil_pattern(phase_next) : 4'b0000;
    end
  end

endmodule

// File: rtl/step_drv.sv
// Stepper-motor driver: linear speed ramp, step strobe, signed position count.
// Build option STEP_HALF_EN selects half-step coil sequencing.
module step_drv
  import step_drv_pkg::*;
#(
  parameter int DIV_W     = 20,
  parameter int START_DIV = 50000,
  parameter int MIN_DIV   = 10000,
  parameter int RAMP_DEC  = 500,
  parameter int POS_W     = 16
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             direct,
  input  logic             enable,
  output logic [3:0]       coil,
  output logic             step_pulse,
  output logic [POS_W-1:0] position,
  output logic             busy
);

  localparam logic [DIV_W-1:0] START_V = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] RAMP_V  = DIV_W'(RAMP_DEC);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] cur_div;
  logic             dir_r;
  logic             step;
  logic [DIV_W-1:0] acc_div;
  logic [DIV_W-1:0] dec_div;

  // Step detection and the clamped next periods for speeding up and slowing down.
  always_comb begin
    step    = (state != IDLE) && (div_cnt == cur_div - 1'b1);
    acc_div = (cur_div >= MIN_V + RAMP_V) ? cur_div - RAMP_V : MIN_V;
    dec_div = (cur_div + RAMP_V >= START_V) ? START_V : cur_div + RAMP_V;
  end

  // Ramp FSM, step divider, direction latch, step strobe and position counter.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      cur_div    <= START_V;
      dir_r      <= 1'b0;
      step_pulse <= 1'b0;
      position   <= '0;
    end else begin
      step_pulse <= step;
      if (step) begin
        position <= dir_r ? position + 1'b1 : position - 1'b1;
      end
      if (state != IDLE) begin
        div_cnt <= step ? '0 : div_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            dir_r   <= direct;
            cur_div <= START_V;
            div_cnt <= '0;
            state   <= ACCEL;
          end
        end
        ACCEL, CRUISE: begin
          if (step && state == ACCEL) begin
            cur_div <= acc_div;
          end
          if (!enable || direct != dir_r) begin
            state <= DECEL;
          end else if (step && state == ACCEL && acc_div == MIN_V) begin
            state <= CRUISE;
          end
        end
        DECEL: begin
          if (step) begin
            cur_div <= dec_div;
            if (dec_div == START_V) begin
              if (!enable) begin
                state <= IDLE;
              end else begin
                dir_r <= direct;
                state <= ACCEL;
              end
            end
          end else if (enable && direct == dir_r) begin
            state <= ACCEL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  step_seq u_seq (
    .clk   (sclk),
    .rst_n (s_rst_n),
    .step  (step),
    .dir   (dir_r),
    .run   (busy),
    .coil  (coil)
  );

endmodule

// File: tb/tb_step_drv.sv
// Testbench for step_drv with a cycle-level behavioural reference model.
// Build option STEP_HALF_EN selects the half-step pattern table here as well.
module tb_step_drv;

  localparam int DIV_W     = 20;
  localparam int START_DIV = 8;
  localparam int MIN_DIV   = 2;
  localparam int RAMP_DEC  = 2;
  localparam int POS_W     = 8;

`ifdef STEP_HALF_EN
  localparam int SEQ_LEN = 8;
  logic [3:0] pat [SEQ_LEN] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int SEQ_LEN = 4;
  logic [3:0] pat [SEQ_LEN] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

  logic             sclk;
  logic             s_rst_n;
  logic             direct;
  logic             enable;
  logic [3:0]       coil;
  logic             step_pulse;
  logic [POS_W-1:0] position;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes;

  // Reference model: motion flag, ramp mode (-1 speeding up, 0 cruising, +1 slowing),
  // current period, cycles left until the next step, direction, phase and position.
  bit         m_moving;
  int         m_ramp;
  int         m_period;
  int         m_left;
  bit         m_dir;
  int         m_idx;
  int         m_pos;
  logic [3:0] m_coil;
  bit         m_step;

  step_drv #(
    .DIV_W     (DIV_W),
    .START_DIV (START_DIV),
    .MIN_DIV   (MIN_DIV),
    .RAMP_DEC  (RAMP_DEC),
    .POS_W     (POS_W)
  ) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .direct     (direct),
    .enable     (enable),
    .coil       (coil),
    .step_pulse (step_pulse),
    .position   (position),
    .busy       (busy)
  );

  // Free-running clock, period 10.
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_moving = 1'b0;
    m_ramp   = 0;
    m_period = START_DIV;
    m_left   = 0;
    m_dir    = 1'b0;
    m_idx    = 0;
    m_pos    = 0;
    m_coil   = 4'b0000;
    m_step   = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs applied before the edge.
  task automatic model_edge();
    m_step = 1'b0;
    if (!m_moving) begin
      if (enable) begin
        m_moving = 1'b1;
        m_dir    = direct;
        m_period = START_DIV;
        m_left   = START_DIV;
        m_ramp   = -1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_step = 1'b1;
        m_pos  = (m_pos + (m_dir ? 1 : -1)) & ((1 << POS_W) - 1);
        m_idx  = (m_idx + (m_dir ? 1 : SEQ_LEN - 1)) % SEQ_LEN;
      end
      if (m_ramp <= 0) begin
        if (m_step && m_ramp < 0) begin
          m_period = (m_period - RAMP_DEC < MIN_DIV) ? MIN_DIV : m_period - RAMP_DEC;
        end
        if (!enable || direct != m_dir) m_ramp = 1;
        else if (m_step && m_ramp < 0 && m_period == MIN_DIV) m_ramp = 0;
      end else begin
        if (m_step) begin
          m_period = (m_period + RAMP_DEC > START_DIV) ? START_DIV : m_period + RAMP_DEC;
          if (m_period == START_DIV) begin
            if (!enable) m_moving = 1'b0;
            else begin
              m_dir  = direct;
              m_ramp = -1;
            end
          end
        end else if (enable && direct == m_dir) begin
          m_ramp = -1;
        end
      end
      if (m_step) m_left = m_period;
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".step_pulse"}, 32'(step_pulse), 32'(m_step));
    check({tag, ".position"},   32'(position),   32'(m_pos));
    check({tag, ".busy"},       32'(busy),       32'(m_moving));
    check({tag, ".coil"},       32'(coil),       32'(m_coil));
  endtask

  // Advance one clock, update the model at the edge and compare at the falling edge.
  task automatic tick(input string tag);
    bit was_moving;
    @(posedge sclk);
    was_moving = m_moving;
    model_edge();
    m_coil = was_moving ? pat[m_idx] : 4'b0000;
    @(negedge sclk);
    check_output(tag);
  endtask

  task automatic apply_stimulus(input logic en, input logic dir);
    enable = en;
    direct = dir;
  endtask

  // Count cycles up to and including the next step strobe, bounded.
  task automatic wait_step(input string tag, output int cyc);
    cyc = 0;
    do begin
      tick(tag);
      cyc++;
    end while (step_pulse !== 1'b1 && cyc < 200);
    check({tag, ".strobe_seen"}, 32'(step_pulse), 32'd1);
    n_strobes++;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 300) begin
      tick(tag);
      cyc++;
    end
    check({tag, ".idle_reached"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int iv;
    int pos_before;
    int exp_iv [5] = '{8, 6, 4, 2, 2};
    int stop_iv [3] = '{2, 4, 6};

    // Reset state
    s_rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    model_reset();
    n_strobes = 0;
    repeat (2) @(negedge sclk);
    check_output("reset");
    s_rst_n = 1'b1;
    tick("idle");

    // Acceleration profile: 8, 6, 4, 2, 2 with coil following the sequence
    apply_stimulus(1'b1, 1'b1);
    tick("accel_start");
    check("accel.busy_rise", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_step("accel", iv);
      check($sformatf("accel.interval%0d", k), 32'(iv), 32'(exp_iv[k]));
      check($sformatf("accel.coil%0d", k), 32'(coil), 32'(pat[(k + 1) % SEQ_LEN]));
    end

    // Stop from cruise: 2, 4, 6 then idle with coils off
    apply_stimulus(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_step("stop", iv);
      check($sformatf("stop.interval%0d", k), 32'(iv), 32'(stop_iv[k]));
    end
    tick("stop_tail");
    tick("stop_tail");
    check("stop.busy", 32'(busy), 32'd0);
    check("stop.coil", 32'(coil), 32'd0);
    check("stop.position", 32'(position), 32'(n_strobes));

    // Reverse while running: slow to the start period, then run backwards
    apply_stimulus(1'b1, 1'b1);
    tick("rev_start");
    for (int k = 0; k < 4; k++) wait_step("rev_accel", iv);
    apply_stimulus(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_step("rev_decel", iv);
      check($sformatf("rev.decel_interval%0d", k), 32'(iv), 32'(stop_iv[k]));
    end
    pos_before = int'(position);
    wait_step("rev_back", iv);
    check("rev.first_back_interval", 32'(iv), 32'(START_DIV));
    check("rev.position_dec", 32'(position), 32'((pos_before - 1) & 8'hFF));
    wait_step("rev_back", iv);
    check("rev.second_back_interval", 32'(iv), 32'(START_DIV - RAMP_DEC));
    apply_stimulus(1'b0, 1'b0);
    wait_idle("rev_stop");

    // Wrap-around: 129 reverse steps from zero
    s_rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge sclk);
    s_rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0);
    for (int k = 0; k < 129; k++) wait_step("wrap", iv);
    check("wrap.position", 32'(position), 32'h7F);
    tick("wrap_after");
    check("wrap.single_strobe", 32'(step_pulse), 32'd0);

    // Turn around into an acceleration, then reset between steps
    apply_stimulus(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) wait_step("turn", iv);
    tick("turn_mid");
    tick("turn_mid");
    s_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.coil", 32'(coil), 32'd0);
    check("rst_mid.position", 32'(position), 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    tick("rst_release");
    check("rst_release.busy", 32'(busy), 32'd1);
    wait_step("rst_release", iv);
    check("rst_release.first_interval", 32'(iv), 32'(START_DIV));

    // Random enable/direction segments against the model
    for (int s = 0; s < 60; s++) begin
      apply_stimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 40)) tick("random");
    end
    apply_stimulus(1'b0, direct);
    wait_idle("random_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
